stream_arb2x1: RTL and testbench

//   Two-input round-robin arbiter with valid/ready handshake; upstream stage of the 2:1 data mux.

---
 rtl/stream_arb2x1_pkg.sv | 17 +
 rtl/stream_arb2x1_pick.sv | 31 +++
 rtl/stream_arb2x1.sv | 84 ++++++++
 tb/tb_stream_arb2x1.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb2x1_pkg.sv
// Shared types and defaults for the 2:1 round-robin stream arbiter.
package stream_arb2x1_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

endpackage

// File: rtl/stream_arb2x1_pick.sv
// Combinational grant: lock state overrides round-robin, prio breaks ties in IDLE.
module stream_arb2x1_pick
    import stream_arb2x1_pkg::*;
(
    input  logic   a_valid,
    input  logic   b_valid,
    input  src_t   prio,
    input  state_t state,
    output logic   grant_a,
    output logic   grant_b
);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            LOCK_A: grant_a = a_valid;
            LOCK_B: grant_b = b_valid;
            default: begin
                if (a_valid && b_valid) begin
                    grant_a = (prio == SRC_A);
                    grant_b = (prio == SRC_B);
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end
            end
        endcase
    end

endmodule

// File: rtl/stream_arb2x1.sv
// Two-input round-robin arbiter with a registered output stage.
// Optional packet locking enabled by defining STREAM_ARB2X1_PKT_LOCK_EN.
module stream_arb2x1
    import stream_arb2x1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_s
);

    src_t   prio;
    state_t state;
    logic   grant_a, grant_b;
    logic   load_en, load;
    src_t   winner;
    logic   win_last;

    stream_arb2x1_pick u_pick (
        .a_valid (a_valid),
        .b_valid (b_valid),
        .prio    (prio),
        .state   (state),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // Readies are forced low during reset even though the empty register could accept.
    assign load_en  = !out_valid || out_ready;
    assign a_ready  = rst_n && load_en && grant_a;
    assign b_ready  = rst_n && load_en && grant_b;
    assign load     = a_ready || b_ready;
    assign winner   = grant_b ? SRC_B : SRC_A;
    assign win_last = grant_b ? b_last : a_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_s     <= 1'b0;
            prio      <= SRC_A;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant_b ? b_data : a_data;
            out_last  <= win_last;
            out_s     <= winner;
            // Inside a locked packet the rotation is frozen.
            if (state == IDLE)
                prio <= (winner == SRC_A) ? SRC_B : SRC_A;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_ARB2X1_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (load) begin
            case (state)
                IDLE:    if (!win_last) state <= (winner == SRC_A) ? LOCK_A : LOCK_B;
                default: if (win_last)  state <= IDLE;
            endcase
        end
    end
`else
    assign state = IDLE;
`endif

endmodule

// File: tb/tb_stream_arb2x1.sv
// Self-checking bench for stream_arb2x1: directed scenarios plus a randomized run against a reference model.
module tb_stream_arb2x1;

    localparam int W = 8;
`ifdef STREAM_ARB2X1_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, a_ready, a_last;
    logic [W-1:0] a_data;
    logic         b_valid, b_ready, b_last;
    logic [W-1:0] b_data;
    logic         out_valid, out_ready, out_last, out_s;
    logic [W-1:0] out_data;

    int checks = 0;
    int errors = 0;

    stream_arb2x1 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_s(out_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 0; a_data = 0; a_last = 1;
        b_valid = 0; b_data = 0; b_last = 1;
        out_ready = 1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1; a_data = 8'h11; a_last = 1;
        b_valid = 1; b_data = 8'h22; b_last = 1;
        out_ready = 1;
        tick(); tick();
        #2;
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_readies: got %b expected 00", {a_ready, b_ready});
        end
        checks++;
        if ({out_valid, out_s, out_last, out_data} !== 11'd0) begin
            errors++; $display("FAIL reset_outputs: got v=%b s=%b l=%b d=%h expected all 0",
                               out_valid, out_s, out_last, out_data);
        end
        tick();
        rst_n = 1'b1;
        #2;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_first_grant: got %b expected 10", {a_ready, b_ready});
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_s !== 1'b0) begin
            errors++; $display("FAIL reset_first_beat: got v=%b d=%h s=%b expected 1 11 0",
                               out_valid, out_data, out_s);
        end
    endtask

    task automatic test_alternation();
        do_reset();
        a_valid = 1; a_data = 8'h11; b_valid = 1; b_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if ({a_ready, b_ready} !== ((i % 2) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL alt_ready[%0d]: got %b expected %b", i, {a_ready, b_ready},
                                   (i % 2) ? 2'b01 : 2'b10);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== ((i % 2) ? 8'h22 : 8'h11) || out_s !== (i % 2)) begin
                errors++; $display("FAIL alt_out[%0d]: got v=%b d=%h s=%b", i, out_valid, out_data, out_s);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 1; a_data = 8'h11; b_valid = 1; b_data = 8'h22;
        tick();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if ({a_ready, b_ready} !== 2'b00 || out_valid !== 1'b1 || out_data !== 8'h11 || out_s !== 1'b0) begin
                errors++; $display("FAIL bp_stall[%0d]: got rdy=%b v=%b d=%h s=%b expected 00 1 11 0",
                                   i, {a_ready, b_ready}, out_valid, out_data, out_s);
            end
            tick();
        end
        out_ready = 1;
        #2;
        checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 01", {a_ready, b_ready});
        end
        tick();
        checks++;
        if (out_data !== 8'h22 || out_s !== 1'b1) begin
            errors++; $display("FAIL bp_release_out: got d=%h s=%b expected 22 1", out_data, out_s);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        b_valid = 1;
        for (int k = 0; k < 3; k++) begin
            b_data = 8'h33 + W'(k);
            #2;
            checks++;
            if ({a_ready, b_ready} !== 2'b01) begin
                errors++; $display("FAIL single_ready[%0d]: got %b expected 01", k, {a_ready, b_ready});
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h33 + W'(k) || out_s !== 1'b1) begin
                errors++; $display("FAIL single_out[%0d]: got v=%b d=%h s=%b expected 1 %h 1",
                                   k, out_valid, out_data, out_s, 8'h33 + W'(k));
            end
        end
    endtask

    // Follows test_single_source: last beat held was 8'h35.
    task automatic test_drain();
        b_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h35) begin
            errors++; $display("FAIL drain: got v=%b d=%h expected 0 35", out_valid, out_data);
        end
    endtask

    task automatic test_packet();
        logic [4:0] seen_s;
        logic [4:0] exp_s;
        int an;
        int bound;
        int got;
        do_reset();
        an = 0; got = 0; bound = 0;
        a_valid = 1; a_data = 8'hA0; a_last = 0;
        b_valid = 1; b_data = 8'h22; b_last = 1;
        seen_s = '0;
        exp_s = LOCK ? 5'b11000 : 5'b01010;  // bit i = out_s of beat i
        while (got < 5 && bound < 50) begin
            logic acc_a;
            logic acc_b;
            #2;
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            tick();
            bound++;
            if (acc_a || acc_b) begin
                seen_s[got] = out_s;
                if (acc_a) begin
                    checks++;
                    if (out_data !== 8'hA0 + W'(an)) begin
                        errors++; $display("FAIL pkt_a_data[%0d]: got %h expected %h", an, out_data, 8'hA0 + W'(an));
                    end
                    an++;
                    a_data = 8'hA0 + W'(an);
                    a_last = (an == 2);
                    if (an == 3) a_valid = 0;
                end
                got++;
            end
        end
        checks++;
        if (got != 5 || seen_s !== exp_s) begin
            errors++; $display("FAIL pkt_order: got beats=%0d s=%b expected 5 %b", got, seen_s, exp_s);
        end
    endtask

    task automatic test_random();
        logic         m_vld, m_last, m_s, m_prio;
        logic [W-1:0] m_data;
        int           m_lock;   // 0 none, 1 locked to a, 2 locked to b
        logic         ga, gb, ld;
        do_reset();
        m_vld = 0; m_last = 0; m_s = 0; m_prio = 0; m_data = 0; m_lock = 0;
        for (int c = 0; c < 400; c++) begin
            #2;
            ga = 0; gb = 0;
            if (!m_vld || out_ready) begin
                if (m_lock == 1)      ga = a_valid;
                else if (m_lock == 2) gb = b_valid;
                else if (a_valid && b_valid) begin ga = !m_prio; gb = m_prio; end
                else begin ga = a_valid; gb = b_valid; end
            end
            checks++;
            if ({a_ready, b_ready} !== {ga, gb}) begin
                errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, {a_ready, b_ready}, {ga, gb});
            end
            ld = ga || gb;
            if (ld) begin
                logic wl;
                wl = gb ? b_last : a_last;
                m_vld = 1; m_data = gb ? b_data : a_data; m_last = wl; m_s = gb;
                if (m_lock == 0) m_prio = !gb;
                if (LOCK) begin
                    if (m_lock == 0 && !wl) m_lock = gb ? 2 : 1;
                    else if (m_lock != 0 && wl) m_lock = 0;
                end
            end else if (out_ready) begin
                m_vld = 0;
            end
            tick();
            checks++;
            if (out_valid !== m_vld || out_data !== m_data || out_last !== m_last || out_s !== m_s) begin
                errors++; $display("FAIL rnd_out[%0d]: got v=%b d=%h l=%b s=%b expected %b %h %b %b",
                                   c, out_valid, out_data, out_last, out_s, m_vld, m_data, m_last, m_s);
            end
            if (!a_valid || ga) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_data = W'($urandom);
                a_last = ($urandom_range(0, 2) == 0);
            end
            if (!b_valid || gb) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_data = W'($urandom);
                b_last = ($urandom_range(0, 2) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_backpressure();
        test_single_source();
        test_drain();
        test_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
